// File: rtl/wave_seg_sequencer_pkg.sv
// Shared widths, FSM state type and segment base-address helper for the
// waveform segment sequencer. Optional feature macro: WAVE_RAND_FALLBACK_EN.
package wave_seq_pkg;

    localparam int SEG_W  = 2;
    localparam int OFF_W  = 8;
    localparam int ADDR_W = SEG_W + OFF_W;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_e;

    // First ROM word of a 256-entry segment.
    function automatic logic [ADDR_W-1:0] seg_base(input logic [SEG_W-1:0] seg);
        return {seg, {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/wave_seg_sequencer_if.sv
// Segment request handshake: requester drives index and dwell with valid,
// the sequencer answers with ready while its one-deep pending slot is empty.
interface wave_seg_sequencer_if;
    import wave_seq_pkg::*;

    logic             req_valid;
    logic [SEG_W-1:0] req_seg;
    logic [7:0]       req_dwell;
    logic             req_ready;

    modport master (output req_valid, output req_seg, output req_dwell, input  req_ready);
    modport slave  (input  req_valid, input  req_seg, input  req_dwell, output req_ready);

endinterface

// File: rtl/wave_seg_sequencer_seg_addr_counter.sv
// Offset counter within the current segment, pass-end detect and the
// remaining-dwell down-counter. The offset wraps naturally at the pass end,
// so the next pass or segment starts at offset 0 with no gap cycle.
module seg_addr_counter
    import wave_seq_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             play_i,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [7:0]       dwell_i,
    output logic [OFF_W-1:0] offset_o,
    output logic             pass_end_o,
    output logic             dwell_zero_o
);

    localparam logic [OFF_W-1:0] STEP_V = OFF_W'(STEP);
    localparam logic [OFF_W-1:0] LAST_V = OFF_W'((1 << OFF_W) - STEP);

    logic [OFF_W-1:0] offset_q, offset_d;
    logic [7:0]       dwell_q, dwell_d;

    // Next offset advances while playing and parks at 0 otherwise; dwell loads or counts down.
    always_comb begin
        offset_d = play_i ? (offset_q + STEP_V) : '0;
        dwell_d  = dwell_q;
        if (load_i) begin
            dwell_d = dwell_i;
        end else if (dec_i) begin
            dwell_d = dwell_q - 8'd1;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset_q <= '0;
            dwell_q  <= '0;
        end else begin
            offset_q <= offset_d;
            dwell_q  <= dwell_d;
        end
    end

    assign offset_o     = offset_q;
    assign pass_end_o   = play_i && (offset_q == LAST_V);
    assign dwell_zero_o = (dwell_q == 8'd0);

endmodule

// File: rtl/wave_seg_sequencer.sv
// Waveform segment sequencer: drives the waveform ROM address, switching
// segments only at pass boundaries from a one-deep request slot.
// Optional feature macro: WAVE_RAND_FALLBACK_EN (play rand_seg for
// DEF_DWELL+1 passes when dwell expires with no request pending).
module wave_seg_sequencer
    import wave_seq_pkg::*;
#(
    parameter int         STEP      = 1,
    parameter logic [7:0] DEF_DWELL = 8'd3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    wave_seg_sequencer_if.slave req,
    input  logic [SEG_W-1:0]  rand_seg,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [SEG_W-1:0]  cur_seg,
    output logic              seg_start,
    output logic              busy
);

    state_e           state_q;
    logic [SEG_W-1:0] cur_seg_q;
    logic             seg_start_q;

    logic             pend_valid_q;
    logic [SEG_W-1:0] pend_seg_q;
    logic [7:0]       pend_dwell_q;

    logic             accept;
    logic             take_pend;
    logic             take_rand;
    logic             dwell_dec;
    logic             to_idle;
    logic [SEG_W-1:0] new_seg;
    logic [7:0]       new_dwell;

    logic [OFF_W-1:0] offset;
    logic             pass_end;
    logic             dwell_zero;

    assign req.req_ready = !pend_valid_q;
    assign accept        = req.req_valid && !pend_valid_q;

    // Decide what happens at the next edge: load, replay, count down or stop.
    always_comb begin
        take_pend = 1'b0;
        take_rand = 1'b0;
        dwell_dec = 1'b0;
        to_idle   = 1'b0;
        case (state_q)
            IDLE: take_pend = run && pend_valid_q;
            PLAY: begin
                if (pass_end) begin
                    if (!run) begin
                        to_idle = 1'b1;
                    end else if (!dwell_zero) begin
                        dwell_dec = 1'b1;
                    end else if (pend_valid_q) begin
                        take_pend = 1'b1;
                    end else begin
`ifdef WAVE_RAND_FALLBACK_EN
                        take_rand = 1'b1;
`else
                        take_rand = 1'b0;
`endif
                    end
                end
            end
            default: to_idle = 1'b1;
        endcase
    end

`ifdef WAVE_RAND_FALLBACK_EN
    assign new_seg = take_pend ? pend_seg_q : rand_seg;
`else
    logic unused_rand_seg;
    assign unused_rand_seg = ^rand_seg;
    assign new_seg         = pend_seg_q;
`endif
    assign new_dwell = take_pend ? pend_dwell_q : DEF_DWELL;

    seg_addr_counter #(.STEP(STEP)) u_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .play_i      (state_q == PLAY),
        .load_i      (take_pend || take_rand),
        .dec_i       (dwell_dec),
        .dwell_i     (new_dwell),
        .offset_o    (offset),
        .pass_end_o  (pass_end),
        .dwell_zero_o(dwell_zero)
    );

    // Playback FSM with registered segment and start-pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_seg_q   <= '0;
            seg_start_q <= 1'b0;
        end else begin
            seg_start_q <= take_pend || take_rand;
            if (take_pend || take_rand) begin
                cur_seg_q <= new_seg;
                state_q   <= PLAY;
            end else if (to_idle) begin
                state_q <= IDLE;
            end
        end
    end

    // One-deep pending request slot; fill and drain never coincide since ready is low when full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_seg_q   <= '0;
            pend_dwell_q <= '0;
        end else if (take_pend) begin
            pend_valid_q <= 1'b0;
        end else if (accept) begin
            pend_valid_q <= 1'b1;
            pend_seg_q   <= req.req_seg;
            pend_dwell_q <= req.req_dwell;
        end
    end

    assign busy      = (state_q == PLAY);
    assign cur_seg   = cur_seg_q;
    assign seg_start = seg_start_q;
    assign rom_addr  = busy ? (seg_base(cur_seg_q) | ADDR_W'(offset)) : '0;

endmodule

// File: doc/wave_seg_sequencer.md
# wave_seg_sequencer

Sequences playback of the four 256-entry waveform segments held in the 1024-word waveform ROM that feeds the DA1/DA2 outputs on `clk_125`. Software or random-source requests (segment index plus dwell count) are queued one deep and applied only at a segment wrap. This keeps the DAC sample stream glitch-free and confines every address strictly to the selected segment. The block replaces free-running address logic and drives the ROM `address` input directly.

## Interface
- `STEP`, 1: offset increment per cycle; power of two, 1..128
- `DEF_DWELL`, 8'd3: dwell loaded for random-fallback segments (only with `WAVE_RAND_FALLBACK_EN`)
- `clk` in 1: sample clock (`clk_125` domain)
- `rst_n` in 1: asynchronous, active-low reset
- `run` in 1: playback enable; sampled at pass boundaries and in IDLE
- `req_valid` in 1: segment request valid
- `req_seg` in 2: requested segment index (base address = seg×256)
- `req_dwell` in 8: extra passes; D → D+1 full passes
- `req_ready` out 1: pending slot empty; request accepted on `req_valid && req_ready`
- `rand_seg` in 2: random segment index from the RanGen bits
- `rom_addr` out 10: registered ROM address, `{cur_seg, offset}`
- `cur_seg` out 2: segment currently playing
- `seg_start` out 1: one-cycle pulse with the first address of a newly loaded segment
- `busy` out 1: state is PLAY

## Operation
- State is a one-entry pending register (`pend_valid`, `pend_seg`, `pend_dwell`) plus an FSM with states IDLE and PLAY.
- `req_ready = !pend_valid`. It is combinational from the register, with no same-cycle bypass.
- IDLE: `rom_addr = 0`. If `run && pend_valid`, the FSM loads `cur_seg/dwell_cnt` from the pending register, sets offset to 0, clears `pend_valid`, pulses `seg_start`, and moves to PLAY.
- PLAY, each cycle: `offset <= offset + STEP` (8-bit, wraps mod 256).
- Pass end is when `offset == 256-STEP`. At pass end, in priority order:
  - `!run`: go to IDLE. The pending register is kept.
  - `dwell_cnt != 0`: decrement, replay the same segment.
  - `pend_valid`: load the pending entry, pulse `seg_start`, free the slot.
  - Otherwise, if `WAVE_RAND_FALLBACK_EN` is defined: load `rand_seg` with dwell `DEF_DWELL` and pulse `seg_start`.
  - Otherwise, with the macro undefined: replay `cur_seg` with dwell 0 and no `seg_start` pulse.
- If a request is accepted in the same cycle the slot is consumed, it is not possible, because ready was low. It is accepted the next cycle.
- `rom_addr` never leaves `[cur_seg×256, cur_seg×256+255]` between loads.

## Timing
- Reset values:
  - `rom_addr=0`, `cur_seg=0`, `seg_start=0`, `busy=0`, `req_ready=1`.
  - FSM=IDLE, `pend_valid=0`, `dwell_cnt=0`, offset=0.
- Accept at edge T (IDLE, `run=1`): `pend_valid` is high after T. At edge T+1, `rom_addr={seg,8'h00}` and `seg_start=1` for exactly that cycle. ROM data is downstream and one cycle later.
- A segment with dwell D occupies exactly (D+1)×256/STEP cycles. The next segment's first address immediately follows the last address, with no gap cycle.
- Reset mid-operation clears everything asynchronously and drops any pending request.

## Configuration
- `WAVE_RAND_FALLBACK_EN` defined: when dwell expires with no pending request, the block plays `rand_seg` for `DEF_DWELL`+1 passes.
- `WAVE_RAND_FALLBACK_EN` undefined: the `rand_seg` input is ignored and the current segment repeats one pass at a time until a request arrives.

## Structure
- Package `wave_seq_pkg` holds:
  - `SEG_W=2` and `OFF_W=8`
  - the state enum (IDLE, PLAY)
  - the `seg_base(seg)` function.
- One sub-module, `seg_addr_counter`, contains the offset counter, the pass-end detect and the dwell down-counter. The top-level module holds the FSM, the pending register and the handshake.

## Test plan
- Reset, then request seg 2 / dwell 0 with STEP=1. Required: `rom_addr` runs 512..767 once, with `seg_start` on 512. With the macro undefined it then repeats 512..767.
- Request seg 1 / dwell 2 followed immediately by seg 3 / dwell 0. Required: 3×256 cycles of 256..511, then 768 on the next cycle with a `seg_start` pulse. `req_ready` is low from the second accept until the load.
- Hold `req_valid` with the slot full. Required: `req_ready=0` and no overwrite; accepted `pend_seg` equals the first request.
- Deassert `run` mid-pass in seg 0. Required: addresses continue to 255, then `rom_addr=0` and `busy=0`. Reassert `run` with pending seg 1. Required: 256 appears one cycle later.
- Set STEP=4 with seg 3. Required: addresses 768, 772 … 1020, then wrap to 768 after 64 cycles.
- With `WAVE_RAND_FALLBACK_EN` defined and `rand_seg=1`, dwell expires with no request. Required: `seg_start` pulses with `rom_addr=256`, followed by 4 passes. Assert `rst_n=0` mid-pass. Required: all outputs return to reset values immediately.
